subband_granule_buffer: RTL and testbench

//  Sits directly downstream of filterbank. Collects its subband_sample stream (32 subbands/slot, 18 slots)

---
 rtl/subband_granule_buffer_pkg.sv | 24 ++
 rtl/subband_granule_buffer_ram.sv | 29 ++
 rtl/subband_granule_buffer.sv | 228 ++++++++++++++++++++++
 tb/tb_subband_granule_buffer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subband_granule_buffer_pkg.sv
// Shared constants and bank state encoding for the subband granule buffer.
// Granule geometry: 32 subbands x 18 time slots = 576 words per bank.
package subband_granule_buffer_pkg;

    localparam int NUM_SB        = 32;
    localparam int GRANULE_SLOTS = 18;
    localparam int GRANULE_LEN   = NUM_SB * GRANULE_SLOTS;
    localparam int SB_W          = $clog2(NUM_SB);
    localparam int SLOT_W        = $clog2(GRANULE_SLOTS);
    localparam int OFF_W         = $clog2(GRANULE_LEN);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    // A bank owned by the reader side cannot accept writes.
    function automatic logic bank_busy(input bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_READING);
    endfunction

endpackage

// File: rtl/subband_granule_buffer_ram.sv
// Ping-pong granule storage: two banks of GRANULE_LEN words, bank select is the address MSB.
// One write port, one read port with a single registered output stage.
module granule_bank_ram
    import subband_granule_buffer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [OFF_W:0]    wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [OFF_W:0]    rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2][GRANULE_LEN];

    // NOTE: storage has no reset; bank state decides which words are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[OFF_W]][wr_addr[OFF_W-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr[OFF_W]][rd_addr[OFF_W-1:0]];
        end
    end

endmodule

// File: rtl/subband_granule_buffer.sv
// Collects filterbank samples slot-major into a ping-pong RAM and replays each granule
// subband-major to the MDCT. Optional macro SUBBAND_FREQ_INVERSION_EN negates odd sb/odd slot.
module subband_granule_buffer
    import subband_granule_buffer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] subband_sample,
    input  logic              subband_sample_valid,
    output logic [DATA_W-1:0] mdct_sample,
    output logic              mdct_valid,
    input  logic              mdct_ready,
    output logic [SB_W-1:0]   mdct_sb,
    output logic              mdct_first,
    output logic              mdct_last,
    output logic              overflow
);

    bank_state_t bank_state [2];

    // Write side
    logic [SB_W-1:0]   wr_sb;
    logic [SLOT_W-1:0] wr_slot;
    logic              wr_bank;
    logic              dropping;
    logic              wr_last;
    logic              wr_drop;
    logic              wr_en;
    logic [OFF_W-1:0]  wr_off;

    assign wr_last = (wr_sb == SB_W'(NUM_SB - 1)) && (wr_slot == SLOT_W'(GRANULE_SLOTS - 1));
    assign wr_drop = dropping || bank_busy(bank_state[wr_bank]);
    assign wr_en   = subband_sample_valid && !wr_drop;
    assign wr_off  = OFF_W'(wr_slot) * OFF_W'(NUM_SB) + OFF_W'(wr_sb);

    // Counters advance on dropped samples too, so subband alignment survives an overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sb    <= '0;
            wr_slot  <= '0;
            wr_bank  <= 1'b0;
            dropping <= 1'b0;
            overflow <= 1'b0;
        end else if (subband_sample_valid) begin
            if (wr_last) begin
                wr_sb    <= '0;
                wr_slot  <= '0;
                dropping <= 1'b0;
                if (!wr_drop) begin
                    wr_bank <= ~wr_bank;
                end
            end else begin
                dropping <= wr_drop;
                if (wr_sb == SB_W'(NUM_SB - 1)) begin
                    wr_sb   <= '0;
                    wr_slot <= wr_slot + SLOT_W'(1);
                end else begin
                    wr_sb <= wr_sb + SB_W'(1);
                end
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Read issue side
    logic              iss_bank;
    logic              iss_active;
    logic [SB_W-1:0]   rd_sb;
    logic [SLOT_W-1:0] rd_slot;
    logic [OFF_W-1:0]  rd_off;
    logic              iss_first;
    logic              iss_last;
    logic              can_issue;
    logic              issue;
    logic              pop;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] push_data;

    logic              pending;
    logic [SB_W-1:0]   pend_sb;
    logic              pend_first;
    logic              pend_last;
    logic              pend_bank;

    logic [1:0]        sk_cnt;
    logic [2:0]        sk_occ;
    logic              sk_wp;
    logic              sk_rp;
    logic [DATA_W-1:0] sk_data  [2];
    logic [SB_W-1:0]   sk_sb    [2];
    logic              sk_first [2];
    logic              sk_last  [2];
    logic              sk_bank  [2];

    assign rd_off    = OFF_W'(rd_slot) * OFF_W'(NUM_SB) + OFF_W'(rd_sb);
    assign iss_first = (rd_sb == '0) && (rd_slot == '0);
    assign iss_last  = (rd_sb == SB_W'(NUM_SB - 1)) && (rd_slot == SLOT_W'(GRANULE_SLOTS - 1));
    assign can_issue = (bank_state[iss_bank] == BANK_FULL) ||
                       ((bank_state[iss_bank] == BANK_READING) && iss_active);
    assign pop       = mdct_valid && mdct_ready;
    // Skid entries plus the read in flight may never exceed two after this cycle's pop.
    assign sk_occ    = {1'b0, sk_cnt} + {2'b00, pending} - {2'b00, pop};
    assign issue     = can_issue && (sk_occ < 3'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_bank   <= 1'b0;
            iss_active <= 1'b0;
            rd_sb      <= '0;
            rd_slot    <= '0;
            pending    <= 1'b0;
            pend_sb    <= '0;
            pend_first <= 1'b0;
            pend_last  <= 1'b0;
            pend_bank  <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                pend_sb    <= rd_sb;
                pend_first <= iss_first;
                pend_last  <= iss_last;
                pend_bank  <= iss_bank;
                iss_active <= !iss_last;
                if (iss_last) begin
                    rd_sb    <= '0;
                    rd_slot  <= '0;
                    iss_bank <= ~iss_bank;
                end else if (rd_slot == SLOT_W'(GRANULE_SLOTS - 1)) begin
                    rd_slot <= '0;
                    rd_sb   <= rd_sb + SB_W'(1);
                end else begin
                    rd_slot <= rd_slot + SLOT_W'(1);
                end
            end
        end
    end

`ifdef SUBBAND_FREQ_INVERSION_EN
    logic pend_odd;

    function automatic logic [DATA_W-1:0] sat_negate(input logic [DATA_W-1:0] x);
        if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
        return -x;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_odd <= 1'b0;
        end else if (issue) begin
            pend_odd <= rd_sb[0] & rd_slot[0];
        end
    end

    assign push_data = pend_odd ? sat_negate(rd_data) : rd_data;
`else
    assign push_data = rd_data;
`endif

    // NOTE: skid entries are reset (unlike the RAM) because they drive the outputs directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sk_cnt <= '0;
            sk_wp  <= 1'b0;
            sk_rp  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                sk_data[i]  <= '0;
                sk_sb[i]    <= '0;
                sk_first[i] <= 1'b0;
                sk_last[i]  <= 1'b0;
                sk_bank[i]  <= 1'b0;
            end
        end else begin
            if (pending) begin
                sk_data[sk_wp]  <= push_data;
                sk_sb[sk_wp]    <= pend_sb;
                sk_first[sk_wp] <= pend_first;
                sk_last[sk_wp]  <= pend_last;
                sk_bank[sk_wp]  <= pend_bank;
                sk_wp           <= ~sk_wp;
            end
            if (pop) begin
                sk_rp <= ~sk_rp;
            end
            sk_cnt <= sk_cnt + {1'b0, pending} - {1'b0, pop};
        end
    end

    // Writer and reader only touch banks in disjoint states, so same-cycle updates never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
        end else begin
            if (wr_en) begin
                bank_state[wr_bank] <= wr_last ? BANK_FULL : BANK_FILLING;
            end
            if (issue && (bank_state[iss_bank] == BANK_FULL)) begin
                bank_state[iss_bank] <= BANK_READING;
            end
            if (pop && sk_last[sk_rp]) begin
                bank_state[sk_bank[sk_rp]] <= BANK_EMPTY;
            end
        end
    end

    granule_bank_ram #(.DATA_W(DATA_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, wr_off}),
        .wr_data (subband_sample),
        .rd_en   (issue),
        .rd_addr ({iss_bank, rd_off}),
        .rd_data (rd_data)
    );

    assign mdct_valid  = (sk_cnt != 2'd0);
    assign mdct_sample = sk_data[sk_rp];
    assign mdct_sb     = sk_sb[sk_rp];
    assign mdct_first  = sk_first[sk_rp];
    assign mdct_last   = sk_last[sk_rp];

endmodule

// File: tb/tb_subband_granule_buffer.sv
// Self-checking bench for subband_granule_buffer: directed scenarios with random data/ready,
// expected streams built from a transposition model of each granule.
module tb_subband_granule_buffer;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  sb;
        logic        first;
        logic        last;
    } item_t;

    logic        clk;
    logic        rst;
    logic [31:0] subband_sample;
    logic        subband_sample_valid;
    logic [31:0] mdct_sample;
    logic        mdct_valid;
    logic        mdct_ready;
    logic [4:0]  mdct_sb;
    logic        mdct_first;
    logic        mdct_last;
    logic        overflow;

    subband_granule_buffer #(.DATA_W(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .subband_sample       (subband_sample),
        .subband_sample_valid (subband_sample_valid),
        .mdct_sample          (mdct_sample),
        .mdct_valid           (mdct_valid),
        .mdct_ready           (mdct_ready),
        .mdct_sb              (mdct_sb),
        .mdct_first           (mdct_first),
        .mdct_last            (mdct_last),
        .overflow             (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ready: 0 = held low, 1 = held high, 2 = random 50%
    int ready_mode = 1;
    initial begin
        mdct_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       mdct_ready = 1'b0;
                1:       mdct_ready = 1'b1;
                default: mdct_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: records accepted items and stall stability, sampled on the falling edge.
    item_t cur;
    item_t held;
    item_t got_q [$];
    int    got_cyc [$];
    bit    hold_armed = 1'b0;
    int    hold_bad = 0;
    bit    ovf_prev = 1'b0;
    int    ovf_cyc = -1;

    assign cur = {mdct_sample, mdct_sb, mdct_first, mdct_last};

    always @(negedge clk) begin
        if (mdct_valid && mdct_ready) begin
            got_q.push_back(cur);
            got_cyc.push_back(cyc);
        end
        if (hold_armed && !(mdct_valid && (cur == held))) hold_bad <= hold_bad + 1;
        hold_armed <= mdct_valid && !mdct_ready && rst;
        held       <= cur;
        if (overflow && !ovf_prev) ovf_cyc <= cyc;
        ovf_prev <= overflow;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] gran [576];
    item_t       exp_q [$];
    int          base = 0;
    int          first_idx = 0;
    int          last_drive_cyc = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // mode 0: slot*32+sb, 1: random, 2: constant
    task automatic fill_granule(input int mode, input logic [31:0] value);
        for (int i = 0; i < 576; i++) begin
            case (mode)
                0:       gran[i] = 32'(i);
                1:       gran[i] = $urandom;
                default: gran[i] = value;
            endcase
        end
    endtask

    // Reference: subband-major replay of the stored slot-major granule.
    task automatic model_granule();
        item_t it;
        logic [31:0] v;
        longint n;
        for (int sb = 0; sb < 32; sb++) begin
            for (int slot = 0; slot < 18; slot++) begin
                v = gran[slot * 32 + sb];
`ifdef SUBBAND_FREQ_INVERSION_EN
                if ((sb % 2 == 1) && (slot % 2 == 1)) begin
                    n = -longint'($signed(v));
                    if (n > 64'sd2147483647) n = 64'sd2147483647;
                    v = n[31:0];
                end
`else
                n = 0;
`endif
                it.data  = v;
                it.sb    = 5'(sb);
                it.first = (sb == 0) && (slot == 0);
                it.last  = (sb == 31) && (slot == 17);
                exp_q.push_back(it);
            end
        end
    endtask

    task automatic send_samples(input int count);
        for (int i = 0; i < count; i++) begin
            @(posedge clk);
            #1;
            subband_sample_valid = 1'b1;
            subband_sample       = gran[i];
            last_drive_cyc       = cyc;
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        subband_sample_valid = 1'b0;
        subband_sample       = '0;
    endtask

    // Waits (bounded) for the expected stream, checks it exactly, and that nothing extra follows.
    task automatic check_stream(input string tag);
        int n;
        int k;
        n = exp_q.size();
        first_idx = base;
        k = 0;
        while ((got_q.size() - base < n) && (k < 20000)) begin
            @(posedge clk);
            k++;
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        check({tag, "_count"}, 64'(got_q.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < got_q.size()) begin
                check($sformatf("%s_item%0d", tag, i), 64'(got_q[base + i]), 64'(exp_q[i]));
            end
        end
        base = got_q.size();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(mdct_valid), 64'(0));
        check({tag, "_sample"}, 64'(mdct_sample), 64'(0));
        check({tag, "_sb"}, 64'(mdct_sb), 64'(0));
        check({tag, "_first"}, 64'(mdct_first), 64'(0));
        check({tag, "_last"}, 64'(mdct_last), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
    endtask

    initial begin
        int g3_cyc;
        rst                  = 1'b1;
        subband_sample       = '0;
        subband_sample_valid = 1'b0;
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: index pattern, ready high: ordering, latency, gapless run
        ready_mode = 1;
        fill_granule(0, '0);
        model_granule();
        send_samples(576);
        go_idle();
        check_stream("t1");
        check("t1_latency", 64'(got_cyc[first_idx]), 64'(last_drive_cyc + 3));
        check("t1_gapless", 64'(got_cyc[first_idx + 575] - got_cyc[first_idx]), 64'(575));
        check("t1_overflow", 64'(overflow), 64'(0));

        // 2: same pattern with random backpressure
        ready_mode = 2;
        fill_granule(0, '0);
        model_granule();
        send_samples(576);
        go_idle();
        check_stream("t2");
        check("t2_stall_stable", 64'(hold_bad), 64'(0));

        // 3: two random granules back to back
        ready_mode = 1;
        fill_granule(1, '0);
        model_granule();
        send_samples(576);
        fill_granule(1, '0);
        model_granule();
        send_samples(576);
        go_idle();
        check_stream("t3");
        check("t3_gapless", 64'(got_cyc[first_idx + 1151] - got_cyc[first_idx]), 64'(1151));
        check("t3_overflow", 64'(overflow), 64'(0));

        // 4: ready low through three granules; only the first two fit
        ready_mode = 0;
        fill_granule(1, '0);
        model_granule();
        send_samples(576);
        fill_granule(1, '0);
        model_granule();
        send_samples(576);
        @(negedge clk);
        check("t4_overflow_before", 64'(overflow), 64'(0));
        fill_granule(1, '0);
        send_samples(1);
        g3_cyc = last_drive_cyc;
        send_samples(576 - 1);
        go_idle();
        check("t4_overflow_cycle", 64'(ovf_cyc), 64'(g3_cyc + 1));
        check("t4_overflow_sticky", 64'(overflow), 64'(1));
        repeat (20) @(posedge clk);
        #1 ready_mode = 1;
        check_stream("t4");
        check("t4_stall_stable", 64'(hold_bad), 64'(0));

        // 5: reset mid-granule discards the partial data and clears everything
        fill_granule(1, '0);
        send_samples(100);
        @(posedge clk);
        #1;
        subband_sample_valid = 1'b0;
        rst                  = 1'b0;
        @(negedge clk);
        check_idle_outputs("t5_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ready_mode = 2;
        fill_granule(1, '0);
        model_granule();
        send_samples(576);
        go_idle();
        check_stream("t5");
        check("t5_overflow", 64'(overflow), 64'(0));

        // 6: constant granules exercising the optional inversion and its saturation corner
        ready_mode = 1;
        fill_granule(2, 32'h0000_0100);
        model_granule();
        send_samples(576);
        fill_granule(2, 32'h8000_0000);
        model_granule();
        send_samples(576);
        go_idle();
        check_stream("t6");
        check("t6_stall_stable", 64'(hold_bad), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
